// File: rtl/fifo_word_packer_pkg.sv
// Shared types for the FIFO word packer: state enum, default sizes
// and the lane-counter width helper.
package fifo_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packState_t;

    localparam int DefDataWidth = 8;
    localparam int DefPackRatio = 4;

    // laneCnt must reach packRatio itself, hence the extra bit.
    function automatic int laneCntWidth(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Downstream word stream of the packer (valid/ready handshake).
// wordParityOut exists only when PACKER_PARITY_EN is defined.
interface fifo_word_packer_if
    import fifo_packer_pkg::*;
#(
    parameter int dataWidth = DefDataWidth,
    parameter int packRatio = DefPackRatio
);

    logic [dataWidth*packRatio-1:0] wordOut;
    logic [packRatio-1:0]           laneMaskOut;
    logic                           wordValidOut;
    logic                           wordReadyIn;
`ifdef PACKER_PARITY_EN
    logic                           wordParityOut;
`endif

    modport master (
        output wordOut,
        output laneMaskOut,
        output wordValidOut,
`ifdef PACKER_PARITY_EN
        output wordParityOut,
`endif
        input  wordReadyIn
    );

    modport slave (
        input  wordOut,
        input  laneMaskOut,
        input  wordValidOut,
`ifdef PACKER_PARITY_EN
        input  wordParityOut,
`endif
        output wordReadyIn
    );

endinterface

// File: rtl/packer_lane_ctrl.sv
// Lane bookkeeping for the packer: lane count, in-flight read,
// pending flush and the FIFO read-issue decision.
module packer_lane_ctrl
    import fifo_packer_pkg::*;
#(
    parameter  int packRatio = DefPackRatio,
    localparam int cntW      = laneCntWidth(packRatio)
) (
    input  logic            clkIn,
    input  logic            rstIn,
    input  logic            isFill,
    input  logic            accept,
    input  logic            fifoEmptyIn,
    input  logic            flushIn,
    output logic [cntW-1:0] laneCnt,
    output logic            rdPending,
    output logic            flushPending,
    output logic            fifoReadEnableOut
);

    localparam logic [cntW:0] RatioW = (cntW + 1)'(packRatio);

    logic [cntW:0] inFlight;

    assign inFlight = {1'b0, laneCnt} + {{cntW{1'b0}}, rdPending};

    // Held low during reset so no read is lost while the packer is cleared.
    assign fifoReadEnableOut = rstIn && isFill && !fifoEmptyIn &&
                               !flushPending && (inFlight < RatioW);

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            laneCnt      <= '0;
            rdPending    <= 1'b0;
            flushPending <= 1'b0;
        end else begin
            rdPending <= fifoReadEnableOut;
            if (accept) begin
                laneCnt      <= '0;
                flushPending <= 1'b0;
            end else begin
                if (rdPending) begin
                    laneCnt <= laneCnt + cntW'(1);
                end
                if (isFill && flushIn && (laneCnt != '0 || rdPending)) begin
                    flushPending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs packRatio FIFO entries into one word with valid/ready output.
// Optional even parity on the word when PACKER_PARITY_EN is defined.
module fifo_word_packer
    import fifo_packer_pkg::*;
#(
    parameter int dataWidth = DefDataWidth,
    parameter int packRatio = DefPackRatio
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    input  logic [dataWidth-1:0] fifoDataIn,
    input  logic                 fifoEmptyIn,
    output logic                 fifoReadEnableOut,
    input  logic                 flushIn,
    fifo_word_packer_if.master   bus
);

    localparam int cntW  = laneCntWidth(packRatio);
    localparam int idxW  = $clog2(packRatio);
    localparam int wordW = dataWidth * packRatio;
    localparam logic [cntW-1:0] LastLane = cntW'(packRatio - 1);

    packState_t state;
    packState_t stateNext;

    logic [wordW-1:0]     wordQ;
    logic [wordW-1:0]     wordNext;
    logic [packRatio-1:0] maskQ;
    logic [packRatio-1:0] maskNext;
    logic                 validQ;
    logic                 validNext;

    logic [cntW-1:0] laneCnt;
    logic [idxW-1:0] laneIdx;
    logic            rdPending;
    logic            flushPending;
    logic            accept;
    logic            capLast;
    logic            flushDone;

    assign accept    = validQ && bus.wordReadyIn;
    assign laneIdx   = laneCnt[idxW-1:0];
    assign capLast   = rdPending && (laneCnt == LastLane);
    assign flushDone = flushPending && !rdPending && (laneCnt != '0);

    packer_lane_ctrl #(
        .packRatio (packRatio)
    ) uLaneCtrl (
        .clkIn             (clkIn),
        .rstIn             (rstIn),
        .isFill            (state == FILL),
        .accept            (accept),
        .fifoEmptyIn       (fifoEmptyIn),
        .flushIn           (flushIn),
        .laneCnt           (laneCnt),
        .rdPending         (rdPending),
        .flushPending      (flushPending),
        .fifoReadEnableOut (fifoReadEnableOut)
    );

    always_comb begin
        stateNext = state;
        wordNext  = wordQ;
        maskNext  = maskQ;
        validNext = validQ;
        unique case (state)
            FILL: begin
                // rdPending is only ever set while laneCnt < packRatio.
                if (rdPending) begin
                    wordNext[laneIdx*dataWidth +: dataWidth] = fifoDataIn;
                    maskNext[laneIdx] = 1'b1;
                end
                if (capLast || flushDone) begin
                    stateNext = HOLD;
                    validNext = 1'b1;
                end
            end
            HOLD: begin
                if (accept) begin
                    stateNext = FILL;
                    validNext = 1'b0;
                    wordNext  = '0;
                    maskNext  = '0;
                end
            end
            default: begin
                stateNext = FILL;
            end
        endcase
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state  <= FILL;
            wordQ  <= '0;
            maskQ  <= '0;
            validQ <= 1'b0;
        end else begin
            state  <= stateNext;
            wordQ  <= wordNext;
            maskQ  <= maskNext;
            validQ <= validNext;
        end
    end

    assign bus.wordOut      = wordQ;
    assign bus.laneMaskOut  = maskQ;
    assign bus.wordValidOut = validQ;

`ifdef PACKER_PARITY_EN
    logic parityQ;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            parityQ <= 1'b0;
        end else begin
            parityQ <= ^wordNext;
        end
    end

    assign bus.wordParityOut = parityQ;
`endif

endmodule
